// File: rtl/riscv_fetch_if.sv
// Instruction-fetch bus bundle: instruction-memory request/response,
// redirect from execute, and the valid/ready handshake toward decode.
// The fetch unit uses the master modport; memory/execute/decode side uses slave.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN adds fetch_misalign.
interface riscv_fetch_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;
    logic            id_valid;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;
    logic            id_ready;
    logic            fetch_busy;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            fetch_misalign;
`endif

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata,
        input  redir_valid,
        input  redir_pc,
        output id_valid,
        output id_instr,
        output id_pc,
        input  id_ready,
        output fetch_busy
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        output fetch_misalign
`endif
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata,
        output redir_valid,
        output redir_pc,
        input  id_valid,
        input  id_instr,
        input  id_pc,
        output id_ready,
        input  fetch_busy
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        input  fetch_misalign
`endif
    );
endinterface

// File: rtl/riscv_fetch.sv
// riscv_fetch: instruction fetch stage.
// Owns the PC, issues one word fetch at a time, buffers returned words with
// their PCs in a small FIFO, and hands them to decode via valid/ready.
// A redirect flushes the FIFO and any in-flight fetch, then restarts at the
// target. Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect
// target raises a sticky fetch_misalign flag and halts fetching).
module riscv_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              QDEPTH   = 2
) (
    input  logic                clk,
    input  logic                rst,
    riscv_fetch_if.master       bus
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0]   QDEPTH_C = CW'(QDEPTH);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1'b1);
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1'b1);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(32'd4);
    localparam logic [XLEN-1:0] PC_ALIGN = ~(XLEN'(32'd3));

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;

    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] req_pc_r;
    logic [XLEN-1:0] redir_target_s;

    logic [XLEN-1:0] q_instr_r [QDEPTH];
    logic [XLEN-1:0] q_pc_r    [QDEPTH];
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [CW-1:0]   count_r;

    logic            issue_s;
    logic            push_s;
    logic            pop_s;
    logic            q_empty_s;
    logic            id_valid_s;
    logic            fetch_blocked_s;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic            misalign_r;

    // Target is taken unmodified; misalignment is flagged instead of hidden.
    assign redir_target_s  = bus.redir_pc;
    assign fetch_blocked_s = misalign_r;
    assign bus.fetch_misalign = misalign_r;

    // Sticky misalign flag, updated by every redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_r <= 1'b0;
        end else if (bus.redir_valid) begin
            misalign_r <= (bus.redir_pc[1:0] != 2'b00);
        end
    end
`else
    // Low address bits of the redirect target are dropped.
    assign redir_target_s  = bus.redir_pc & PC_ALIGN;
    assign fetch_blocked_s = 1'b0;
`endif

    // Head-of-queue view; a redirect suppresses id_valid in the same cycle.
    assign q_empty_s  = (count_r == {CW{1'b0}});
    assign id_valid_s = !q_empty_s && !bus.redir_valid;
    assign pop_s      = id_valid_s && bus.id_ready;

    assign bus.id_valid   = id_valid_s;
    assign bus.id_instr   = q_empty_s ? {XLEN{1'b0}} : q_instr_r[rd_ptr_r];
    assign bus.id_pc      = q_empty_s ? {XLEN{1'b0}} : q_pc_r[rd_ptr_r];
    assign bus.imem_req   = issue_s;
    assign bus.imem_addr  = pc_r;
    assign bus.fetch_busy = (state_r != ST_ISSUE);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_ISSUE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state, fetch issue and queue push decisions.
    always_comb begin
        state_nxt_s = state_r;
        issue_s     = 1'b0;
        push_s      = 1'b0;
        case (state_r)
            ST_ISSUE: begin
                // A free slot is required so the eventual response always fits.
                if (!rst && !bus.redir_valid && !fetch_blocked_s && (count_r < QDEPTH_C)) begin
                    issue_s     = 1'b1;
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (bus.redir_valid) begin
                    // A response in the redirect cycle is the stale one itself.
                    if (bus.imem_rvalid) begin
                        state_nxt_s = ST_ISSUE;
                    end else begin
                        state_nxt_s = ST_DROP;
                    end
                end else if (bus.imem_rvalid) begin
                    push_s      = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (bus.imem_rvalid) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            default: begin
                state_nxt_s = ST_ISSUE;
            end
        endcase
    end

    // Program counter and PC of the outstanding request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r     <= RESET_PC;
            req_pc_r <= RESET_PC;
        end else if (bus.redir_valid) begin
            pc_r <= redir_target_s;
        end else if (issue_s) begin
            req_pc_r <= pc_r;
            pc_r     <= pc_r + PC_STEP;
        end
    end

    // Instruction FIFO; a redirect flushes it and wins over push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < QDEPTH; i++) begin
                q_instr_r[i] <= {XLEN{1'b0}};
                q_pc_r[i]    <= {XLEN{1'b0}};
            end
        end else if (bus.redir_valid) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                q_instr_r[wr_ptr_r] <= bus.imem_rdata;
                q_pc_r[wr_ptr_r]    <= req_pc_r;
                wr_ptr_r            <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_fetch.sv
// Directed bench for riscv_fetch: startup streaming, reset mid-fetch,
// back-pressure, redirects (in-flight, coincident with response/pop,
// wrap-around) and the optional FETCH_MISALIGN_TRAP_EN behaviour.
module tb_riscv_fetch;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    riscv_fetch_if #(.XLEN(32)) bus ();

    riscv_fetch #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hDEAD_0013;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        pass_cnt        = 0;
        total_cnt       = 0;
        rst             = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0000_0000;
        bus.redir_valid = 1'b0;
        bus.redir_pc    = 32'h0000_0000;
        bus.id_ready    = 1'b1;

        // Reset values
        tick();
        tick();
        chk("rst_req",    {31'd0, bus.imem_req},   32'd0);
        chk("rst_addr",   bus.imem_addr,           32'h0000_0000);
        chk("rst_valid",  {31'd0, bus.id_valid},   32'd0);
        chk("rst_instr",  bus.id_instr,            32'h0000_0000);
        chk("rst_pc",     bus.id_pc,               32'h0000_0000);
        chk("rst_busy",   {31'd0, bus.fetch_busy}, 32'd0);

        // 1: streaming with latency 1, decode always ready
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("s1_req",  {31'd0, bus.imem_req},   32'd1);
            chk("s1_addr", bus.imem_addr,           32'(4 * k));
            chk("s1_busy", {31'd0, bus.fetch_busy}, 32'd0);
            if (k > 0) begin
                chk("s1_valid", {31'd0, bus.id_valid}, 32'd1);
                chk("s1_pc",    bus.id_pc,             32'(4 * (k - 1)));
                chk("s1_instr", bus.id_instr,          mem_word(32'(4 * (k - 1))));
            end
            tick();
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(32'(4 * k));
            settle();
            chk("s1_nocomb", {31'd0, bus.id_valid},   32'd0);
            chk("s1_wbusy",  {31'd0, bus.fetch_busy}, 32'd1);
            tick();
            bus.imem_rvalid = 1'b0;
        end
        bus.id_ready = 1'b0;
        settle();
        chk("s1_pc3",    bus.id_pc,    32'h0000_000C);
        chk("s1_instr3", bus.id_instr, mem_word(32'h0000_000C));
        chk("s1_addr4",  bus.imem_addr, 32'h0000_0010);

        // 5: reset asserted in WAIT with an entry queued
        tick();
        chk("s5_busy_pre",  {31'd0, bus.fetch_busy}, 32'd1);
        chk("s5_pc_pre",    bus.id_pc,               32'h0000_000C);
        rst = 1'b1;
        settle();
        chk("s5_req",   {31'd0, bus.imem_req},   32'd0);
        chk("s5_addr",  bus.imem_addr,           32'h0000_0000);
        chk("s5_valid", {31'd0, bus.id_valid},   32'd0);
        chk("s5_instr", bus.id_instr,            32'h0000_0000);
        chk("s5_pc",    bus.id_pc,               32'h0000_0000);
        chk("s5_busy",  {31'd0, bus.fetch_busy}, 32'd0);
        tick();
        rst             = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hBAD0_BAD0;
        settle();
        chk("s5_restart_req",  {31'd0, bus.imem_req}, 32'd1);
        chk("s5_restart_addr", bus.imem_addr,         32'h0000_0000);
        tick();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(32'h0000_0000);
        settle();
        chk("s5_late_dropped", {31'd0, bus.id_valid}, 32'd0);
        tick();
        bus.imem_rvalid = 1'b0;
        settle();
        chk("s5_first_pc",    bus.id_pc,     32'h0000_0000);
        chk("s5_first_instr", bus.id_instr,  mem_word(32'h0000_0000));

        // 2: back-pressure fills the queue with pc 0 and 4
        chk("s2_addr4", bus.imem_addr, 32'h0000_0004);
        tick();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(32'h0000_0004);
        tick();
        bus.imem_rvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
        end
        settle();
        chk("s2_full_req",  {31'd0, bus.imem_req},   32'd0);
        chk("s2_full_busy", {31'd0, bus.fetch_busy}, 32'd0);
        chk("s2_full_pc",   bus.id_pc,               32'h0000_0000);
        bus.id_ready = 1'b1;
        settle();
        chk("s2_pop0_instr", bus.id_instr,          mem_word(32'h0000_0000));
        chk("s2_pop0_req",   {31'd0, bus.imem_req}, 32'd0);
        tick();
        chk("s2_pop1_pc",    bus.id_pc,             32'h0000_0004);
        chk("s2_pop1_instr", bus.id_instr,          mem_word(32'h0000_0004));
        chk("s2_resume_req", {31'd0, bus.imem_req}, 32'd1);
        chk("s2_resume_addr", bus.imem_addr,        32'h0000_0008);

        // 3: redirect while request to 8 is outstanding, latency 3
        tick();
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 32'h0000_0100;
        settle();
        chk("s3_redir_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("s3_redir_req",   {31'd0, bus.imem_req}, 32'd0);
        tick();
        bus.redir_valid = 1'b0;
        settle();
        chk("s3_drop_busy", {31'd0, bus.fetch_busy}, 32'd1);
        chk("s3_drop_req",  {31'd0, bus.imem_req},   32'd0);
        tick();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(32'h0000_0008);
        tick();
        bus.imem_rvalid = 1'b0;
        settle();
        chk("s3_stale_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("s3_new_req",     {31'd0, bus.imem_req}, 32'd1);
        chk("s3_new_addr",    bus.imem_addr,         32'h0000_0100);
        tick();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(32'h0000_0100);
        tick();
        bus.imem_rvalid = 1'b0;
        bus.id_ready    = 1'b0;
        settle();
        chk("s3_first_pc",    bus.id_pc,    32'h0000_0100);
        chk("s3_first_instr", bus.id_instr, mem_word(32'h0000_0100));

        // 4: redirect coincident with response and a ready head
        tick();
        bus.id_ready    = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(32'h0000_0104);
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 32'h0000_0200;
        settle();
        chk("s4_same_valid", {31'd0, bus.id_valid}, 32'd0);
        tick();
        bus.imem_rvalid = 1'b0;
        bus.redir_valid = 1'b0;
        settle();
        chk("s4_empty",    {31'd0, bus.id_valid},   32'd0);
        chk("s4_no_drop",  {31'd0, bus.fetch_busy}, 32'd0);
        chk("s4_req",      {31'd0, bus.imem_req},   32'd1);
        chk("s4_addr",     bus.imem_addr,           32'h0000_0200);
        tick();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(32'h0000_0200);
        tick();
        bus.imem_rvalid = 1'b0;
        settle();
        chk("s4_pc", bus.id_pc, 32'h0000_0200);

        // 6: redirect to the top word, PC wraps to zero
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 32'hFFFF_FFFC;
        settle();
        chk("s6_redir_req", {31'd0, bus.imem_req}, 32'd0);
        tick();
        bus.redir_valid = 1'b0;
        settle();
        chk("s6_top_addr", bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(32'hFFFF_FFFC);
        tick();
        bus.imem_rvalid = 1'b0;
        settle();
        chk("s6_top_pc",   bus.id_pc,             32'hFFFF_FFFC);
        chk("s6_wrap_req", {31'd0, bus.imem_req}, 32'd1);
        chk("s6_wrap_addr", bus.imem_addr,        32'h0000_0000);

        // Misaligned redirect target
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 32'h0000_0102;
        tick();
        bus.redir_valid = 1'b0;
        settle();
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("s6_misalign",    {31'd0, bus.fetch_misalign}, 32'd1);
        chk("s6_mis_req",     {31'd0, bus.imem_req},       32'd0);
        tick();
        chk("s6_mis_hold",    {31'd0, bus.imem_req},       32'd0);
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 32'h0000_0300;
        tick();
        bus.redir_valid = 1'b0;
        settle();
        chk("s6_mis_clear",   {31'd0, bus.fetch_misalign}, 32'd0);
        chk("s6_aligned_req", {31'd0, bus.imem_req},       32'd1);
        chk("s6_aligned_addr", bus.imem_addr,              32'h0000_0300);
`else
        chk("s6_lsb_req",  {31'd0, bus.imem_req}, 32'd1);
        chk("s6_lsb_addr", bus.imem_addr,         32'h0000_0100);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
